// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared opcodes, widths and enums for the ALU issue controller
// Contents: datapath widths, opcode constants, controller state enum, op-class enum.

package alu_ctrl_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 32;

  localparam logic [OP_W-1:0] OP_ADD    = 8'h00;
  localparam logic [OP_W-1:0] OP_SUB    = 8'h01;
  localparam logic [OP_W-1:0] OP_MUL    = 8'h02;
  localparam logic [OP_W-1:0] OP_MEM_LO = 8'h10;
  localparam logic [OP_W-1:0] OP_MEM_HI = 8'h1F;
  localparam logic [OP_W-1:0] OP_JUMP   = 8'h31;
  localparam logic [OP_W-1:0] OP_NOP    = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB
  } state_e;

  typedef enum logic [1:0] {
    CLS_ARITH,
    CLS_MEM,
    CLS_JUMP,
    CLS_ILLEGAL
  } op_class_e;

endpackage

// File: rtl/alu_op_class.sv
// rtl/alu_op_class.sv - combinational opcode classifier and execution latency lookup
// Ports:
//   opcode_i    decoded opcode
//   op_class_o  arithmetic / mem / jump / illegal
//   latency_o   countdown load value (MUL_LATENCY for MUL, 1 otherwise)

module alu_op_class
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic [OP_W-1:0] opcode_i,
  output op_class_e       op_class_o,
  output logic [3:0]      latency_o
);

  always_comb begin
    op_class_o = CLS_ILLEGAL;
    latency_o  = 4'd1;
    if (opcode_i == OP_ADD || opcode_i == OP_SUB || opcode_i == OP_MUL) begin
      op_class_o = CLS_ARITH;
    end else if (opcode_i >= OP_MEM_LO && opcode_i <= OP_MEM_HI) begin
      op_class_o = CLS_MEM;
    end else if (opcode_i == OP_JUMP) begin
      op_class_o = CLS_JUMP;
    end
    if (opcode_i == OP_MUL) begin
      latency_o = 4'(MUL_LATENCY);
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - decode-to-ALU issue sequencer with writeback hold and jump flush
// Ports:
//   clock, reset_c                      clock, async active-low reset
//   dec_valid/dec_ready, dec_*          decoded operation handshake and payload
//   alu_val1/2, alu_instr, alu_stall    registered ALU inputs, result-held indicator
//   alu_out, alu_write_en, alu_pc_*     ALU results sampled at end of execution
//   wb_valid/wb_stall, wb_*             captured result towards writeback
//   flush_in                            squash in-flight operation
//   flush_valid, flush_pc               one-cycle jump redirect
//   illegal_op, busy                    unsupported-op pulse, not idle

module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned DST_W       = 5
) (
  input  logic              clock,
  input  logic              reset_c,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [OP_W-1:0]   dec_opcode,
  input  logic [DATA_W-1:0] dec_val1,
  input  logic [DATA_W-1:0] dec_val2,
  input  logic [DST_W-1:0]  dec_dst,
  output logic [DATA_W-1:0] alu_val1,
  output logic [DATA_W-1:0] alu_val2,
  output logic [OP_W-1:0]   alu_instr,
  output logic              alu_stall,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_write_en,
  input  logic [PC_W-1:0]   alu_pc_branch,
  input  logic              alu_pc_branch_val,
  output logic              wb_valid,
  input  logic              wb_stall,
  output logic [DST_W-1:0]  wb_dst,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic              wb_mem,
  input  logic              flush_in,
  output logic              flush_valid,
  output logic [PC_W-1:0]   flush_pc,
  output logic              illegal_op,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  op_class_e         cls_q, cls_d;
  logic [OP_W-1:0]   instr_q, instr_d;
  logic [DATA_W-1:0] val1_q, val1_d, val2_q, val2_d;
  logic [DST_W-1:0]  dst_q, dst_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DST_W-1:0]  wb_dst_q, wb_dst_d;
  logic              wb_we_q, wb_we_d;
  logic              wb_mem_q, wb_mem_d;
  logic              flush_valid_q, flush_valid_d;
  logic [PC_W-1:0]   flush_pc_q, flush_pc_d;
  logic              illegal_q, illegal_d;

  op_class_e  dec_cls;
  logic [3:0] dec_lat;
  logic       accept;

  alu_op_class #(.MUL_LATENCY(MUL_LATENCY)) u_op_class (
    .opcode_i   (dec_opcode),
    .op_class_o (dec_cls),
    .latency_o  (dec_lat)
  );

  // A new op may enter while the previous result drains out of WB.
  assign dec_ready = ((state_q == ST_IDLE) || (state_q == ST_WB && !wb_stall)) && !flush_in;
  assign accept    = dec_valid && dec_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cls_d         = cls_q;
    instr_d       = instr_q;
    val1_d        = val1_q;
    val2_d        = val2_q;
    dst_d         = dst_q;
    wb_data_d     = wb_data_q;
    wb_dst_d      = wb_dst_q;
    wb_we_d       = wb_we_q;
    wb_mem_d      = wb_mem_q;
    flush_pc_d    = flush_pc_q;
    flush_valid_d = 1'b0;
    illegal_d     = 1'b0;

    case (state_q)
      ST_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          case (cls_q)
            CLS_ARITH, CLS_MEM: begin
              wb_data_d = alu_out;
              wb_we_d   = alu_write_en;
              wb_mem_d  = (cls_q == CLS_MEM);
              wb_dst_d  = dst_q;
              state_d   = ST_WB;
            end
            CLS_JUMP: begin
              // A jump without a valid target is reported rather than redirecting fetch.
              if (alu_pc_branch_val) begin
                flush_valid_d = 1'b1;
                flush_pc_d    = alu_pc_branch;
              end else begin
                illegal_d = 1'b1;
              end
              state_d = ST_IDLE;
              instr_d = OP_NOP;
            end
            default: begin
              state_d = ST_IDLE;
              instr_d = OP_NOP;
            end
          endcase
        end
      end
      ST_WB: begin
        if (!wb_stall) begin
          state_d = ST_IDLE;
          instr_d = OP_NOP;
        end
      end
      default: ;
    endcase

    // Accept only happens from IDLE or a draining WB, both of which already
    // leave state IDLE / alu_instr NOP, so an illegal op only needs the pulse.
    if (accept) begin
      if (dec_cls == CLS_ILLEGAL) begin
        illegal_d = 1'b1;
      end else begin
        state_d = ST_EXEC;
        cnt_d   = dec_lat;
        cls_d   = dec_cls;
        instr_d = dec_opcode;
        val1_d  = dec_val1;
        val2_d  = dec_val2;
        dst_d   = dec_dst;
      end
    end

    // Flush overrides any capture or redirect decided above.
    if (flush_in) begin
      state_d       = ST_IDLE;
      instr_d       = OP_NOP;
      cnt_d         = 4'd0;
      wb_data_d     = wb_data_q;
      wb_dst_d      = wb_dst_q;
      wb_we_d       = wb_we_q;
      wb_mem_d      = wb_mem_q;
      flush_pc_d    = flush_pc_q;
      flush_valid_d = 1'b0;
      illegal_d     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_c) begin
    if (!reset_c) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      cls_q         <= CLS_ILLEGAL;
      instr_q       <= OP_NOP;
      val1_q        <= '0;
      val2_q        <= '0;
      dst_q         <= '0;
      wb_data_q     <= '0;
      wb_dst_q      <= '0;
      wb_we_q       <= 1'b0;
      wb_mem_q      <= 1'b0;
      flush_valid_q <= 1'b0;
      flush_pc_q    <= '0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cls_q         <= cls_d;
      instr_q       <= instr_d;
      val1_q        <= val1_d;
      val2_q        <= val2_d;
      dst_q         <= dst_d;
      wb_data_q     <= wb_data_d;
      wb_dst_q      <= wb_dst_d;
      wb_we_q       <= wb_we_d;
      wb_mem_q      <= wb_mem_d;
      flush_valid_q <= flush_valid_d;
      flush_pc_q    <= flush_pc_d;
      illegal_q     <= illegal_d;
    end
  end

  assign alu_val1    = val1_q;
  assign alu_val2    = val2_q;
  assign alu_instr   = instr_q;
  assign alu_stall   = (state_q == ST_WB);
  assign wb_valid    = (state_q == ST_WB);
  assign wb_dst      = wb_dst_q;
  assign wb_data     = wb_data_q;
  assign wb_we       = wb_we_q;
  assign wb_mem      = wb_mem_q;
  assign flush_valid = flush_valid_q;
  assign flush_pc    = flush_pc_q;
  assign illegal_op  = illegal_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl

module tb_alu_issue_ctrl;

  localparam int L = 4;

  logic        clock, reset_c;
  logic        dec_valid, dec_ready;
  logic [7:0]  dec_opcode;
  logic [31:0] dec_val1, dec_val2;
  logic [4:0]  dec_dst;
  logic [31:0] alu_val1, alu_val2;
  logic [7:0]  alu_instr;
  logic        alu_stall;
  logic [31:0] alu_out;
  logic        alu_write_en;
  logic [31:0] alu_pc_branch;
  logic        alu_pc_branch_val;
  logic        wb_valid, wb_stall;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        wb_we, wb_mem;
  logic        flush_in, flush_valid;
  logic [31:0] flush_pc;
  logic        illegal_op, busy;

  alu_issue_ctrl #(.MUL_LATENCY(L), .DST_W(5)) dut (
    .clock(clock), .reset_c(reset_c),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
    .dec_val1(dec_val1), .dec_val2(dec_val2), .dec_dst(dec_dst),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_instr(alu_instr), .alu_stall(alu_stall),
    .alu_out(alu_out), .alu_write_en(alu_write_en),
    .alu_pc_branch(alu_pc_branch), .alu_pc_branch_val(alu_pc_branch_val),
    .wb_valid(wb_valid), .wb_stall(wb_stall), .wb_dst(wb_dst), .wb_data(wb_data),
    .wb_we(wb_we), .wb_mem(wb_mem),
    .flush_in(flush_in), .flush_valid(flush_valid), .flush_pc(flush_pc),
    .illegal_op(illegal_op), .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit alu_emul = 1'b1;

  // Transaction-level model: one pending op with an absolute sample cycle,
  // and at most one held result.
  bit          m_pend, m_hold, m_fv, m_ill;
  int          m_sample, m_cls;
  logic [7:0]  m_instr;
  logic [31:0] m_v1, m_v2, m_data, m_fpc;
  logic [4:0]  m_dst, m_wdst;
  bit          m_we, m_mem;

  // 0 arith, 1 mem, 2 jump, 3 illegal
  function automatic int cls_of(logic [7:0] op);
    if (op == 8'h00 || op == 8'h01 || op == 8'h02) return 0;
    if (op >= 8'h10 && op <= 8'h1F) return 1;
    if (op == 8'h31) return 2;
    return 3;
  endfunction

  function automatic int lat_of(logic [7:0] op);
    return (op == 8'h02) ? L : 1;
  endfunction

  function automatic bit m_ready();
    return !m_pend && (!m_hold || !wb_stall) && !flush_in;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_hold = 0; m_fv = 0; m_ill = 0; m_instr = 8'hFF;
    m_v1 = '0; m_v2 = '0; m_data = '0; m_fpc = '0; m_dst = '0; m_wdst = '0;
    m_we = 0; m_mem = 0; m_sample = 0; m_cls = 3;
  endtask

  task automatic model_update();
    bit acc, nf, ni;
    nf = 0; ni = 0;
    acc = dec_valid && m_ready();
    if (flush_in) begin
      m_pend = 0; m_hold = 0; m_instr = 8'hFF;
    end else begin
      if (m_pend && cyc == m_sample) begin
        m_pend = 0;
        if (m_cls == 2) begin
          if (alu_pc_branch_val) begin nf = 1; m_fpc = alu_pc_branch; end
          else ni = 1;
          m_instr = 8'hFF;
        end else begin
          m_hold = 1; m_data = alu_out; m_we = alu_write_en;
          m_mem = (m_cls == 1); m_wdst = m_dst;
        end
      end else if (m_hold && !wb_stall) begin
        m_hold = 0; m_instr = 8'hFF;
      end
      if (acc) begin
        if (cls_of(dec_opcode) == 3) ni = 1;
        else begin
          m_pend = 1; m_cls = cls_of(dec_opcode);
          m_sample = cyc + 1 + lat_of(dec_opcode);
          m_instr = dec_opcode; m_v1 = dec_val1; m_v2 = dec_val2; m_dst = dec_dst;
        end
      end
    end
    m_fv = nf; m_ill = ni;
  endtask

  task automatic compare();
    chk("dec_ready", dec_ready, m_ready());
    chk("alu_instr", alu_instr, m_instr);
    if (m_instr != 8'hFF) begin
      chk("alu_val1", alu_val1, m_v1);
      chk("alu_val2", alu_val2, m_v2);
    end
    chk("wb_valid", wb_valid, m_hold);
    chk("alu_stall", alu_stall, m_hold);
    chk("busy", busy, m_pend || m_hold);
    if (m_hold) begin
      chk("wb_data", wb_data, m_data);
      chk("wb_dst", wb_dst, m_wdst);
      chk("wb_we", wb_we, m_we);
      chk("wb_mem", wb_mem, m_mem);
    end
    chk("flush_valid", flush_valid, m_fv);
    if (m_fv) chk("flush_pc", flush_pc, m_fpc);
    chk("illegal_op", illegal_op, m_ill);
  endtask

  // Called right after a negedge with inputs already set; returns at the next negedge.
  task automatic step();
    if (alu_emul) begin
      case (alu_instr)
        8'h01:   alu_out = alu_val1 - alu_val2;
        8'h02:   alu_out = alu_val1 * alu_val2;
        default: alu_out = alu_val1 + alu_val2;
      endcase
      alu_write_en = 1'b1;
    end
    #1;
    if (!reset_c) model_reset();
    compare();
    if (reset_c) model_update();
    cyc++;
    @(negedge clock);
  endtask

  task automatic offer(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d);
    dec_valid = 1; dec_opcode = op; dec_val1 = a; dec_val2 = b; dec_dst = d;
  endtask

  initial begin
    reset_c = 0; dec_valid = 0; dec_opcode = 0; dec_val1 = 0; dec_val2 = 0; dec_dst = 0;
    alu_out = 0; alu_write_en = 0; alu_pc_branch = 0; alu_pc_branch_val = 0;
    wb_stall = 0; flush_in = 0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("reset_dec_ready", dec_ready, 1);
    chk("reset_alu_instr", alu_instr, 8'hFF);
    chk("reset_wb_valid", wb_valid, 0);
    reset_c = 1;
    step();

    // ADD 5+7 -> 12 at cycle 3
    offer(8'h00, 32'd5, 32'd7, 5'd3);
    step();
    dec_valid = 0;
    step(); step();
    chk("add_wb_valid_c3", wb_valid, 1);
    chk("add_wb_data", wb_data, 32'd12);
    chk("add_wb_dst", wb_dst, 5'd3);
    chk("add_wb_we", wb_we, 1);
    step(); step();

    // MUL 6*7 -> 42 at cycle 2+L
    offer(8'h02, 32'd6, 32'd7, 5'd9);
    step();
    dec_valid = 0;
    for (int k = 1; k <= 1 + L; k++) begin
      #1;
      chk("mul_ready_low", dec_ready, 0);
      chk("mul_wb_early", wb_valid, 0);
      step();
    end
    chk("mul_wb_valid", wb_valid, 1);
    chk("mul_wb_data", wb_data, 32'd42);
    step(); step();

    // SUB 9-4 with three stall cycles
    offer(8'h01, 32'd9, 32'd4, 5'd1);
    step();
    dec_valid = 0;
    step(); step();
    wb_stall = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("sub_wb_valid_held", wb_valid, 1);
      chk("sub_wb_data_stable", wb_data, 32'd5);
      chk("sub_alu_stall", alu_stall, 1);
      chk("sub_ready_low", dec_ready, 0);
      step();
    end
    wb_stall = 0;
    #1;
    chk("sub_wb_valid_last", wb_valid, 1);
    chk("sub_ready_release", dec_ready, 1);
    step();
    chk("sub_wb_done", wb_valid, 0);
    step();

    // Jump to 0x100
    alu_pc_branch = 32'h100; alu_pc_branch_val = 1;
    offer(8'h31, 32'd0, 32'd0, 5'd0);
    step();
    dec_valid = 0;
    step(); step();
    chk("jump_flush_valid", flush_valid, 1);
    chk("jump_flush_pc", flush_pc, 32'h100);
    chk("jump_no_wb", wb_valid, 0);
    step();
    chk("jump_flush_pulse", flush_valid, 0);
    step();

    // Illegal opcode 8'h33
    offer(8'h33, 32'd1, 32'd2, 5'd2);
    step();
    dec_valid = 0;
    chk("illegal_pulse", illegal_op, 1);
    chk("illegal_no_issue", alu_instr, 8'hFF);
    chk("illegal_idle", busy, 0);
    step();
    chk("illegal_pulse_end", illegal_op, 0);
    step();

    // flush_in during MUL EXEC, coincident with a new offer
    offer(8'h02, 32'd3, 32'd3, 5'd4);
    step();
    dec_valid = 0;
    step(); step();
    flush_in = 1;
    offer(8'h00, 32'd1, 32'd1, 5'd5);
    #1;
    chk("flush_ready_low", dec_ready, 0);
    step();
    flush_in = 0; dec_valid = 0;
    chk("flush_idle", busy, 0);
    chk("flush_nop", alu_instr, 8'hFF);
    for (int k = 0; k < L + 2; k++) begin
      chk("flush_no_wb", wb_valid, 0);
      step();
    end

    // Async reset mid-EXEC
    offer(8'h02, 32'd5, 32'd5, 5'd6);
    step();
    dec_valid = 0;
    step(); step();
    reset_c = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_alu_instr", alu_instr, 8'hFF);
    chk("rst_alu_val1", alu_val1, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_dec_ready", dec_ready, 1);
    step();
    reset_c = 1;
    for (int k = 0; k < L + 2; k++) step();

    // Randomized traffic against the model
    alu_emul = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] op;
      case ($urandom_range(0, 9))
        0, 8:    op = 8'h00;
        1, 9:    op = 8'h01;
        2:       op = 8'h02;
        3, 4:    op = 8'h10 + 8'($urandom_range(0, 15));
        5:       op = 8'h31;
        6:       op = 8'h30 + 8'($urandom_range(0, 3));
        default: op = 8'($urandom);
      endcase
      dec_valid = ($urandom_range(0, 1) == 1);
      dec_opcode = op; dec_val1 = $urandom; dec_val2 = $urandom; dec_dst = 5'($urandom);
      alu_out = $urandom; alu_write_en = ($urandom_range(0, 1) == 1);
      alu_pc_branch = $urandom; alu_pc_branch_val = ($urandom_range(0, 4) != 0);
      wb_stall = ($urandom_range(0, 9) < 3);
      flush_in = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencer between the decode stage and the ALU: accepts one decoded operation at a time over a valid/ready handshake and drives the ALU operand/opcode inputs from registers. It waits the opcode-dependent execution latency (single-cycle arithmetic, multi-cycle MUL), then captures the ALU result and presents it to writeback, holding it while writeback stalls. Jump results become a one-cycle fetch flush; an external flush squashes the in-flight operation.

## Interface
- MUL_LATENCY, 4: cycles from ALU inputs driven to MUL result valid (2..15).
- DST_W, 5: destination register index width.
- clock  in  1  system clock.
- reset_c  in  1  asynchronous, active-low reset.
- dec_valid  in  1  decode offers an operation.
- dec_ready  out  1  controller accepts this cycle.
- dec_opcode  in  `INSTR_OPCODE  opcode.
- dec_val1, dec_val2  in  `REG_FILE_RANGE  operands.
- dec_dst  in  DST_W  destination register.
- alu_val1, alu_val2  out  `REG_FILE_RANGE  registered ALU operands.
- alu_instr  out  `INSTR_OPCODE  registered ALU opcode; 8'hFF when idle.
- alu_stall  out  1  high while a result is held in WB.
- alu_out  in  `REG_FILE_RANGE  ALU result.
- alu_write_en  in  1  ALU result-writes-register flag.
- alu_pc_branch  in  `PC_WIDTH  jump target.
- alu_pc_branch_val  in  1  jump target valid.
- wb_valid  out  1  result presented to writeback.
- wb_stall  in  1  writeback cannot accept.
- wb_dst  out  DST_W  destination register.
- wb_data  out  `REG_FILE_RANGE  captured result.
- wb_we  out  1  register write (captured alu_write_en).
- wb_mem  out  1  result is a memory address (opcode 8'h1X).
- flush_in  in  1  squash in-flight operation.
- flush_valid  out  1  one-cycle jump flush pulse.
- flush_pc  out  `PC_WIDTH  jump target.
- illegal_op  out  1  one-cycle pulse: accepted opcode unsupported.
- busy  out  1  state != IDLE.

## Operation
- States IDLE, EXEC, WB. Reset: IDLE, all outputs 0 except alu_instr = 8'hFF and dec_ready = 1.
- dec_ready = (IDLE or (WB and !wb_stall)) and !flush_in.
- Accept (dec_valid & dec_ready): register operands/opcode/dst to alu_*; load 4-bit counter with MUL_LATENCY for 8'h02, else 1; go EXEC.
- Classes: 8'h00/01/02 arithmetic; 8'h10-8'h1F mem; 8'h31 jump; all other opcodes (incl. 8'h30, 8'h32, 8'h33) illegal.
- Illegal: illegal_op pulses the cycle after accept; no ALU issue (alu_instr stays 8'hFF), no wb, stays IDLE.
- EXEC: counter decrements each cycle; alu_* held. At counter == 0 sample ALU outputs:
  - arithmetic/mem: capture wb_data = alu_out, wb_we = alu_write_en, wb_mem per class; go WB.
  - jump: flush_valid = 1, flush_pc = alu_pc_branch for one cycle (if alu_pc_branch_val, else illegal_op); go IDLE, no wb.
- WB: wb_valid = 1; wb_* stable while wb_stall. Leaves when !wb_stall: to EXEC if a new op is accepted that cycle, else IDLE; alu_instr returns to 8'hFF on exit to IDLE.
- flush_in: in any state, next state IDLE, wb_valid and pending capture cleared, no flush_valid, alu_instr = 8'hFF; wins over accept and capture in the same cycle.
- Reset mid-operation: immediate return to reset values; the result is discarded.

## Timing
- Accept at cycle 0; alu_* valid cycle 1; ADD/SUB/mem result sampled end of cycle 2; wb_valid cycle 3.
- MUL: sampled end of cycle 1+MUL_LATENCY; wb_valid cycle 2+MUL_LATENCY.
- Jump: flush_valid cycle 3.
- Back-to-back single-cycle ops with no wb_stall: one accept every 3 cycles (accept overlaps WB cycle).
- wb_stall for N cycles extends WB by N cycles; no data loss.

## Structure
- alu_ctrl_pkg: opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_MEM_HI, OP_JUMP, OP_NOP = 8'hFF), state enum, op-class enum.
- One combinational sub-module alu_op_class: opcode -> class + latency; everything else in alu_issue_ctrl using RST_FF registers.

## Test plan
- ADD 5+7, dst 3, wb_stall 0 -> wb_valid cycle 3, wb_data 12, wb_dst 3, wb_we 1.
- MUL 6*7, MUL_LATENCY 4 -> wb_valid exactly cycle 6, data 42; dec_ready low cycles 1-5.
- SUB 9-4 with wb_stall high 3 cycles -> wb_valid held 4 cycles, wb_data 5 stable, alu_stall high, dec_ready low until stall drops.
- Jump target 0x100 -> flush_valid one cycle at cycle 3, flush_pc 0x100, no wb_valid; opcode 8'h33 -> illegal_op pulse, no ALU issue.
- flush_in during MUL EXEC and coincident with dec_valid -> no wb, not accepted, IDLE next cycle; reset_c low mid-EXEC -> all outputs at reset values asynchronously.
